// File: rtl/wave_pkg.sv
// wave_pkg: shared encodings for the waveform front-panel controller
// Holds wave-select codes, controller and press_pulse state encodings,
// and the arbitrated event codes passed between arbitration and the FSM.
package wave_pkg;

    typedef enum logic [1:0] {WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW} wave_t;

    typedef enum logic [1:0] {S_BOOT, S_IDLE, S_WAIT} ctrl_state_t;

    typedef enum logic [1:0] {PP_IDLE, PP_PRESS, PP_HOLD} pp_state_t;

    typedef enum logic [1:0] {EV_NONE, EV_MODE, EV_UP, EV_DOWN} ev_t;

endpackage

// File: rtl/press_pulse.sv
// press_pulse: turns a synchronized active-low button level into press/held flags
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_btn_n      : button level, low = pressed
//   o_press      : high for the one cycle after the first low sample
//   o_held       : high from the second consecutive low sample until release
module press_pulse
    import wave_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_press,
    output logic o_held
);

    pp_state_t r_state;
    logic      r_press;
    logic      r_held;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= PP_IDLE;
            r_press <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= i_btn_n ? PP_IDLE : (r_state == PP_IDLE) ? PP_PRESS : PP_HOLD;
            r_press <= !i_btn_n && r_state == PP_IDLE;
            r_held  <= !i_btn_n && r_state != PP_IDLE;
        end
    end

    assign o_press = r_press;
    assign o_held  = r_held;

endmodule

// File: rtl/wave_ctrl.sv
// wave_ctrl: front-panel controller feeding wave select and phase increment to the DDS
// Ports:
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_btn_mode/up/down       : active-low synchronized button levels
//   i_cfg_ready              : generator accepts the configuration
//   o_cfg_valid              : configuration valid and held stable
//   o_wave_sel, o_freq_idx   : current waveform and frequency step
//   o_phase_inc              : PINC_STEP * (o_freq_idx + 1)
module wave_ctrl
    import wave_pkg::*;
#(
    parameter int                FREQ_W     = 4,
    parameter int                PINC_W     = 32,
    parameter logic [PINC_W-1:0] PINC_STEP  = 32'd85_899,
    parameter logic [23:0]       REPEAT_CYC = 24'd5_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_btn_mode,
    input  logic              i_btn_up,
    input  logic              i_btn_down,
    input  logic              i_cfg_ready,
    output logic              o_cfg_valid,
    output logic [1:0]        o_wave_sel,
    output logic [FREQ_W-1:0] o_freq_idx,
    output logic [PINC_W-1:0] o_phase_inc
);

    logic w_mode_p, w_mode_h, w_up_p, w_up_h, w_dn_p, w_dn_h;

    press_pulse u_mode (.i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_btn_mode), .o_press(w_mode_p), .o_held(w_mode_h));
    press_pulse u_up   (.i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_btn_up),   .o_press(w_up_p),   .o_held(w_up_h));
    press_pulse u_down (.i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_btn_down), .o_press(w_dn_p),   .o_held(w_dn_h));

    ctrl_state_t       r_state;
    logic [23:0]       r_rep_cnt;
    logic [1:0]        r_rep_sel;
    logic              r_pend_valid;
    ev_t               r_pend_ev;
    wave_t             r_wave;
    logic [FREQ_W-1:0] r_idx;
    logic [PINC_W-1:0] r_pinc;
    logic              r_valid;

    logic [1:0]        w_sel;
    logic              w_sel_chg;
    logic              w_rep;
    ev_t               w_ev;
    ev_t               w_act_ev;
    logic              w_eff;
    wave_t             w_next_wave;
    logic [FREQ_W-1:0] w_next_idx;
    logic [PINC_W-1:0] w_next_pinc;

    // {up, down} one-hot selection of the held button driving auto-repeat; up wins.
    assign w_sel       = {w_up_h, w_dn_h & ~w_up_h};
    // A switch between two held buttons restarts the count; the switching cycle never fires.
    assign w_sel_chg   = r_rep_sel != 2'b00 && r_rep_sel != w_sel;
    assign w_rep       = w_sel != 2'b00 && !w_sel_chg && r_rep_cnt == REPEAT_CYC - 24'd1;
    assign w_ev        = w_mode_p ? EV_MODE :
                         (w_up_p || (w_rep && w_sel[1])) ? EV_UP :
                         (w_dn_p || (w_rep && w_sel[0])) ? EV_DOWN : EV_NONE;
    // In IDLE a pending event takes the slot over any new one that cycle.
    assign w_act_ev    = (r_state != S_IDLE) ? EV_NONE : r_pend_valid ? r_pend_ev : w_ev;
    assign w_eff       = w_act_ev == EV_MODE ||
                         (w_act_ev == EV_UP && r_idx != '1) ||
                         (w_act_ev == EV_DOWN && r_idx != '0);
    assign w_next_wave = (w_act_ev == EV_MODE) ? wave_t'(r_wave + 2'd1) : r_wave;
    assign w_next_idx  = (w_act_ev == EV_UP) ? r_idx + FREQ_W'(1) :
                         (w_act_ev == EV_DOWN) ? r_idx - FREQ_W'(1) : r_idx;
    assign w_next_pinc = PINC_STEP * (PINC_W'(w_next_idx) + PINC_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_BOOT;
            r_rep_cnt    <= '0;
            r_rep_sel    <= 2'b00;
            r_pend_valid <= 1'b0;
            r_pend_ev    <= EV_NONE;
            r_wave       <= WAVE_SINE;
            r_idx        <= '0;
            r_pinc       <= PINC_STEP;
            r_valid      <= 1'b0;
        end else begin
            r_rep_sel <= w_sel;
            r_rep_cnt <= (w_sel == 2'b00 || w_sel_chg || r_rep_cnt == REPEAT_CYC - 24'd1) ? '0 : r_rep_cnt + 24'd1;
            case (r_state)
                S_BOOT: begin
                    r_state <= S_WAIT;
                    r_valid <= 1'b1;
                end
                S_IDLE: begin
                    r_pend_valid <= 1'b0;
                    if (w_eff) begin
                        r_wave  <= w_next_wave;
                        r_idx   <= w_next_idx;
                        r_pinc  <= w_next_pinc;
                        r_valid <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_ev != EV_NONE && !r_pend_valid) begin
                        r_pend_valid <= 1'b1;
                        r_pend_ev    <= w_ev;
                    end
                    if (i_cfg_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign o_cfg_valid = r_valid;
    assign o_wave_sel  = r_wave;
    assign o_freq_idx  = r_idx;
    assign o_phase_inc = r_pinc;

endmodule

// File: doc/wave_ctrl.md
# wave_ctrl

Front-panel controller for the waveform generator. Turns three synchronized, active-low push-button levels into one-cycle press events and arbitrates them. Applies the winning event to the waveform-select and frequency-step registers, then hands the resulting configuration to the generator datapath over a valid/ready handshake. Sits between the board button inputs and the DDS phase accumulator / waveform lookup.

## Interface
- FREQ_W, 4 — width of frequency-step index (16 steps).
- PINC_W, 32 — width of phase-increment output.
- PINC_STEP, 32'd85_899 — phase increment per step (1 kHz at 50 MHz, 32-bit accumulator).
- REPEAT_CYC, 24'd5_000_000 — hold cycles per auto-repeat event; must be ≥ 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_btn_mode  in  1  mode button, active-low level, already synchronized.
- i_btn_up  in  1  frequency-up button, active-low.
- i_btn_down  in  1  frequency-down button, active-low.
- i_cfg_ready  in  1  generator accepts the configuration.
- o_cfg_valid  out  1  configuration outputs are valid and held stable.
- o_wave_sel  out  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
- o_freq_idx  out  FREQ_W  current frequency step.
- o_phase_inc  out  PINC_W  PINC_STEP × (o_freq_idx+1), truncated to PINC_W.

## Operation
- Each button feeds one press_pulse instance, a 3-state FSM:
  - IDLE→PRESS on low; PRESS→HOLD on low, else IDLE; HOLD stays while low, else IDLE.
  - o_press = (state==PRESS); o_held = (state==HOLD).
- Auto-repeat applies to up/down only:
  - A single REPEAT_CYC counter runs while the selected held button's o_held is high. Up is selected if both are held.
  - The counter clears when that o_held drops or the selection changes.
  - At count REPEAT_CYC-1 it emits a repeat event and reloads 0.
- Arbitration is fixed priority: mode > up > down, with press and repeat treated alike. One event per cycle; losing events in the same cycle are dropped.
- Event effect:
  - mode: wave_sel+1, wrapping 3→0.
  - up: freq_idx+1, saturating at 2^FREQ_W-1.
  - down: freq_idx-1, saturating at 0.
  - An event causing no change, i.e. at saturation, is consumed silently and does not assert valid.
- Controller FSM:
  - S_BOOT: entered on reset. Advances to S_WAIT next cycle with valid=1, presenting the defaults.
  - S_IDLE: on an effective event (or a pending one), registers update on that edge and the FSM goes to S_WAIT.
  - S_WAIT: o_cfg_valid=1; all config outputs are frozen. On valid&ready, go to S_IDLE.
- Pending slot, single entry:
  - The first arbitrated event arriving in S_WAIT is stored; later ones are dropped until the slot empties.
  - The slot is consumed in S_IDLE the cycle after the handshake.
- o_phase_inc is registered and updated on the same edge as o_freq_idx.

## Timing
- Reset values:
  - State S_BOOT, o_cfg_valid 0, o_wave_sel 0, o_freq_idx 0, o_phase_inc PINC_STEP.
  - press_pulse instances IDLE, repeat counter 0, pending slot empty.
- First cycle after i_rst deasserts: o_cfg_valid=1 with the default values.
- Button low first sampled at edge N:
  - o_press high in cycle N+1.
  - New config and o_cfg_valid visible in cycle N+2 (2-cycle latency).
- Handshake: transfer at the edge where valid&ready. o_cfg_valid is low the following cycle.
  - With a pending event, valid returns one cycle later: exactly one low cycle.
- i_cfg_ready held high: each effective event gives a one-cycle valid pulse.
- Repeat:
  - o_held rises at N+2.
  - First repeat event at N+2+REPEAT_CYC-1; subsequent ones every REPEAT_CYC cycles.
- i_rst mid-handshake or mid-hold: immediate return to reset values; the pending event is discarded. A still-low button re-enters PRESS and produces a new event after reset.
- A press shorter than one sample produces no event. A press of exactly one sample produces a press but never o_held.

## Structure
- Shared package wave_pkg holds:
  - Wave-select encodings WAVE_SINE/SQUARE/TRI/SAW.
  - Controller state encodings.
  - press_pulse state encodings.
- One sub-module: press_pulse, instantiated three times. The controller holds arbitration, repeat counter, pending slot, FSM and config registers.

## Test plan
- Reset release, ready=1 → valid high exactly one cycle with wave_sel=0, freq_idx=0, phase_inc=85_899.
- Mode pressed 5 times, ready=1 → wave_sel sequence 1,2,3,0,1, each valid two cycles after first low sample.
- Up pressed 16 times from idx 0 → idx reaches 15 and phase_inc=1_374_384; the 16th press produces no valid. Down at idx 0 likewise produces no valid.
- Mode and up pressed on the same cycle → wave_sel +1, freq_idx unchanged, one valid only.
- Up held 30 cycles with REPEAT_CYC=8 → idx 1 at the press, then +1 at 7, 15 and 23 cycles after o_held rises (idx 4); release stops repeats.
- ready=0 while mode is pressed twice, then up → outputs frozen during the wait.
  - Ready high for one cycle → handshake, one low cycle, then the second mode applied (pending slot).
  - The up event is dropped; reset mid-wait gives all defaults.
